// File: rtl/addr8u_seq32.sv
// addr8u_seq32: 32-bit unsigned adder built from one time-shared 8-bit slice
// adder, low byte first. With CHECK=1 each slice is computed twice (second
// time with operands swapped) and compared; mismatches trigger bounded
// retries, then an abort flagged on err.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready request handshake (a, b, cin captured on accept)
//   a, b, cin         operands and carry-in
//   fi_en             fault injection: flips bit 0 of an EXEC slice result
//   out_valid/out_ready result handshake
//   sum, cout         result A+B+cin mod 2^32 and carry-out of bit 31
//   err               result aborted after retry exhaustion
//   fault_cnt         saturating count of slice mismatches since reset
module addr8u_seq32 #(
  parameter int unsigned CHECK     = 1,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  input  logic        fi_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sum,
  output logic        cout,
  output logic        err,
  output logic [7:0]  fault_cnt
);

  localparam bit         USE_CHECK = (CHECK != 0);
  localparam logic [2:0] MAX_R     = 3'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, EXEC, VERIFY, DONE} state_t;

  state_t      state_q;
  logic [31:0] a_q, b_q, sum_q;
  logic [1:0]  idx_q;
  logic        carry_q, cout_q, err_q, in_ready_q, out_valid_q;
  logic [2:0]  retry_q;
  logic [8:0]  tent_q;
  logic [7:0]  fc_q;

  logic [7:0]  op_x, op_y;
  logic [8:0]  slice_d, exec_d, commit_val;
  logic        commit_en;

  // The single slice adder; VERIFY feeds it the operands swapped.
  always_comb begin
    op_x = a_q[{idx_q, 3'b000} +: 8];
    op_y = b_q[{idx_q, 3'b000} +: 8];
    if (state_q == VERIFY) begin
      op_x = b_q[{idx_q, 3'b000} +: 8];
      op_y = a_q[{idx_q, 3'b000} +: 8];
    end
    slice_d = {1'b0, op_x} + {1'b0, op_y} + {8'b0, carry_q};
    exec_d  = slice_d ^ {8'b0, fi_en};
  end

  always_comb begin
    commit_en  = 1'b0;
    commit_val = tent_q;
    if (state_q == EXEC && !USE_CHECK) begin
      commit_en  = 1'b1;
      commit_val = exec_d;
    end else if (state_q == VERIFY && slice_d == tent_q) begin
      commit_en  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      err_q       <= 1'b0;
      retry_q     <= '0;
      tent_q      <= '0;
      fc_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            carry_q    <= cin;
            idx_q      <= '0;
            retry_q    <= '0;
            err_q      <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          tent_q <= exec_d;
          if (USE_CHECK) state_q <= VERIFY;
        end
        VERIFY: begin
          if (slice_d != tent_q) begin
            if (fc_q != 8'hFF) fc_q <= fc_q + 8'd1;
            if (retry_q < MAX_R) begin
              retry_q <= retry_q + 3'd1;
              state_q <= EXEC;
            end else begin
              err_q   <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          // out_valid rises one cycle after entering DONE.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Slice commit shared by the unchecked EXEC path and a matching VERIFY.
      if (commit_en) begin
        sum_q[{idx_q, 3'b000} +: 8] <= commit_val[7:0];
        carry_q <= commit_val[8];
        retry_q <= '0;
        idx_q   <= idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          cout_q  <= commit_val[8];
          state_q <= DONE;
        end else begin
          state_q <= EXEC;
        end
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign err       = err_q;
  assign fault_cnt = fc_q;

endmodule
